// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the signal controller and the lamp drivers; latches the first fault and forces safe lamp states.
// Latency: one cycle of pass-through from the lamp inputs to the safe outputs. No backpressure; the inputs are sampled every cycle.
// Optional MONITOR_FLASH_EN makes both lights flash RED/DARK while a fault is held (the default is steady RED).
module traffic_conflict_monitor #(
  parameter int MIN_YELLOW_CYC = 3,
  parameter int MAX_GREEN_CYC  = 200,
  parameter int CONFIRM_CYC    = 2,
  parameter int FLASH_HALF_CYC = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] light_ns,
  input  logic [1:0] light_ew,
  input  logic [1:0] pedestrian_signal,
  input  logic       fault_clr,
  output logic [1:0] safe_light_ns,
  output logic [1:0] safe_light_ew,
  output logic [1:0] safe_ped,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
  localparam logic [1:0] BAD    = 2'b11;
  localparam logic [1:0] WALK   = 2'b10;

  localparam int CW = $clog2(CONFIRM_CYC + 1);
  localparam int YW = $clog2(MIN_YELLOW_CYC + 1);
  localparam int GW = $clog2(MAX_GREEN_CYC + 1);
  localparam logic [CW-1:0] C_MAX  = CW'(CONFIRM_CYC);
  localparam logic [CW-1:0] C_LAST = CW'(CONFIRM_CYC - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(MIN_YELLOW_CYC);
  localparam logic [GW-1:0] G_MAX  = GW'(MAX_GREEN_CYC);
  localparam logic [GW-1:0] G_LAST = GW'(MAX_GREEN_CYC - 1);

  if (FLASH_HALF_CYC < 1) begin : g_bad_flash
    $error("FLASH_HALF_CYC must be at least 1");
  end

  // Index 0 is NS, index 1 is EW.
  logic [1:0]    lt_q    [2];
  logic [1:0]    lt_prev [2];
  logic [1:0]    ped_q;
  logic [CW-1:0] pcnt    [1:3];
  logic [YW-1:0] ycnt    [2];
  logic [GW-1:0] gcnt    [2];

  logic [3:1] lvl;
  logic [6:1] qual;
  logic [2:0] code_new;
  logic       any_qual, clr_req, latch_evt, clr_evt;

  function automatic logic illegal_step(input logic [1:0] from, input logic [1:0] to);
    return (from == GREEN  && to == RED)   ||
           (from == YELLOW && to == GREEN) ||
           (from == RED    && to == YELLOW);
  endfunction

  always_comb begin
    lvl[1] = (lt_q[0] != RED) && (lt_q[1] != RED);
    lvl[2] = (ped_q == WALK) && ((lt_q[0] != RED) || (lt_q[1] != RED));
    lvl[3] = (lt_q[0] == BAD) || (lt_q[1] == BAD) || (ped_q == BAD);
    qual = '0;
    for (int i = 1; i <= 3; i++) begin
      qual[i] = lvl[i] && (pcnt[i] >= C_LAST);
    end
    for (int l = 0; l < 2; l++) begin
      qual[4] = qual[4] | illegal_step(lt_prev[l], lt_q[l]);
      qual[5] = qual[5] | ((lt_prev[l] == YELLOW) && (lt_q[l] == RED) && (ycnt[l] < Y_MAX));
      qual[6] = qual[6] | ((lt_q[l] == GREEN) && (gcnt[l] >= G_LAST));
    end
    code_new = 3'd0;
    for (int c = 6; c >= 1; c--) begin
      if (qual[c]) code_new = 3'(c);
    end
    any_qual  = |qual;
    clr_req   = fault && fault_clr && !(|lvl);
    // A clear request that coincides with a fresh cause re-latches instead of clearing.
    latch_evt = any_qual && (!fault || clr_req);
    clr_evt   = clr_req && !any_qual;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_q      <= 2'b00;
      fault      <= 1'b0;
      fault_code <= 3'd0;
      for (int l = 0; l < 2; l++) begin
        lt_q[l]    <= RED;
        lt_prev[l] <= RED;
        ycnt[l]    <= '0;
        gcnt[l]    <= '0;
      end
      for (int i = 1; i <= 3; i++) pcnt[i] <= '0;
    end else begin
      lt_q[0] <= light_ns;
      lt_q[1] <= light_ew;
      ped_q   <= pedestrian_signal;
      for (int l = 0; l < 2; l++) lt_prev[l] <= lt_q[l];

      if (latch_evt) begin
        fault      <= 1'b1;
        fault_code <= code_new;
      end else if (clr_evt) begin
        fault      <= 1'b0;
        fault_code <= 3'd0;
      end

      if (clr_evt) begin
        for (int l = 0; l < 2; l++) begin
          ycnt[l] <= '0;
          gcnt[l] <= '0;
        end
        for (int i = 1; i <= 3; i++) pcnt[i] <= '0;
      end else begin
        for (int i = 1; i <= 3; i++) begin
          if (!lvl[i])              pcnt[i] <= '0;
          else if (pcnt[i] != C_MAX) pcnt[i] <= pcnt[i] + 1'b1;
        end
        for (int l = 0; l < 2; l++) begin
          if (lt_q[l] != YELLOW)     ycnt[l] <= '0;
          else if (ycnt[l] != Y_MAX) ycnt[l] <= ycnt[l] + 1'b1;
          if (lt_q[l] != GREEN)      gcnt[l] <= '0;
          else if (gcnt[l] != G_MAX) gcnt[l] <= gcnt[l] + 1'b1;
        end
      end
    end
  end

`ifdef MONITOR_FLASH_EN
  localparam int FW = $clog2(FLASH_HALF_CYC + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FLASH_HALF_CYC - 1);

  logic [FW-1:0] flash_cnt;
  logic          flash_dark;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flash_cnt  <= '0;
      flash_dark <= 1'b0;
    end else if (latch_evt) begin
      flash_cnt  <= '0;
      flash_dark <= 1'b0;
    end else if (fault) begin
      if (flash_cnt == F_LAST) begin
        flash_cnt  <= '0;
        flash_dark <= ~flash_dark;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    safe_light_ns = lt_q[0];
    safe_light_ew = lt_q[1];
    safe_ped      = ped_q;
    if (fault) begin
      safe_ped = 2'b00;
`ifdef MONITOR_FLASH_EN
      safe_light_ns = flash_dark ? BAD : RED;
      safe_light_ew = flash_dark ? BAD : RED;
`else
      safe_light_ns = RED;
      safe_light_ew = RED;
`endif
    end
  end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor with default parameters; covers both builds of MONITOR_FLASH_EN.
module tb_traffic_conflict_monitor;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] light_ns = 2'b00, light_ew = 2'b00, pedestrian_signal = 2'b00;
  logic       fault_clr = 1'b0;
  logic [1:0] safe_light_ns, safe_light_ew, safe_ped;
  logic       fault;
  logic [2:0] fault_code;

  int errors = 0;
  int checks = 0;

  traffic_conflict_monitor dut (
    .clk(clk), .reset(reset),
    .light_ns(light_ns), .light_ew(light_ew), .pedestrian_signal(pedestrian_signal),
    .fault_clr(fault_clr),
    .safe_light_ns(safe_light_ns), .safe_light_ew(safe_light_ew), .safe_ped(safe_ped),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic apply(input logic [1:0] ns, input logic [1:0] ew, input logic [1:0] ped);
    light_ns = ns;
    light_ew = ew;
    pedestrian_signal = ped;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fault_clr = 1'b0;
    apply(2'b00, 2'b00, 2'b00);
    #7;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if ({safe_light_ns, safe_light_ew, safe_ped, fault, fault_code} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want all zero", {safe_light_ns, safe_light_ew, safe_ped, fault, fault_code});
    end
    do_reset();
    ticks(2);
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle: fault=%b code=%0d want 0/0", fault, fault_code);
    end
  endtask

  task automatic test_passthrough();
    do_reset();
    apply(2'b10, 2'b00, 2'b01);
    #1;
    checks++;
    if (safe_light_ns !== 2'b00) begin
      errors++;
      $display("FAIL pass_latency: safe_ns=%b want 00 before edge", safe_light_ns);
    end
    tick();
    checks++;
    if ({safe_light_ns, safe_light_ew, safe_ped} !== 6'b10_00_01) begin
      errors++;
      $display("FAIL pass_value: got %b want 100001", {safe_light_ns, safe_light_ew, safe_ped});
    end
  endtask

  task automatic test_conflict();
    do_reset();
    apply(2'b10, 2'b10, 2'b10);
    ticks(2);
    checks++;
    if (fault !== 1'b0 || safe_light_ns !== 2'b10) begin
      errors++;
      $display("FAIL conflict_early: fault=%b safe_ns=%b want 0/10", fault, safe_light_ns);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd1) begin
      errors++;
      $display("FAIL conflict_latch: fault=%b code=%0d want 1/1", fault, fault_code);
    end
    checks++;
    if ({safe_light_ns, safe_light_ew, safe_ped} !== 6'd0) begin
      errors++;
      $display("FAIL conflict_safe: got %b want 000000", {safe_light_ns, safe_light_ew, safe_ped});
    end
  endtask

  task automatic test_clear();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd1) begin
      errors++;
      $display("FAIL clear_blocked: fault=%b code=%0d want 1/1", fault, fault_code);
    end
    apply(2'b00, 2'b00, 2'b00);
    ticks(3);
    checks++;
    if (fault_code !== 3'd1) begin
      errors++;
      $display("FAIL clear_no_overwrite: code=%0d want 1", fault_code);
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0) begin
      errors++;
      $display("FAIL clear_done: fault=%b code=%0d want 0/0", fault, fault_code);
    end
    ticks(3);
    checks++;
    if (fault !== 1'b0 || safe_light_ns !== 2'b00) begin
      errors++;
      $display("FAIL clear_stays: fault=%b safe_ns=%b want 0/00", fault, safe_light_ns);
    end
  endtask

  task automatic test_level_codes();
    logic [1:0] t_ns [2] = '{2'b00, 2'b11};
    logic [1:0] t_ew [2] = '{2'b10, 2'b00};
    logic [1:0] t_pd [2] = '{2'b10, 2'b00};
    logic [2:0] t_cd [2] = '{3'd2, 3'd3};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      apply(t_ns[k], t_ew[k], t_pd[k]);
      ticks(2);
      checks++;
      if (fault !== 1'b0) begin
        errors++;
        $display("FAIL level%0d_early: fault=%b want 0", k, fault);
      end
      tick();
      checks++;
      if (fault !== 1'b1 || fault_code !== t_cd[k]) begin
        errors++;
        $display("FAIL level%0d_latch: fault=%b code=%0d want 1/%0d", k, fault, fault_code, t_cd[k]);
      end
    end
  endtask

  task automatic test_illegal_transition();
    do_reset();
    apply(2'b10, 2'b00, 2'b00);
    ticks(3);
    apply(2'b00, 2'b00, 2'b00);
    tick();
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL g2r_early: fault=%b want 0", fault);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd4) begin
      errors++;
      $display("FAIL g2r_latch: fault=%b code=%0d want 1/4", fault, fault_code);
    end
    do_reset();
    apply(2'b00, 2'b01, 2'b00);
    ticks(2);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd4) begin
      errors++;
      $display("FAIL r2y_latch: fault=%b code=%0d want 1/4", fault, fault_code);
    end
  endtask

  task automatic test_short_yellow();
    do_reset();
    apply(2'b10, 2'b00, 2'b00);
    ticks(3);
    apply(2'b01, 2'b00, 2'b00);
    ticks(2);
    apply(2'b00, 2'b00, 2'b00);
    tick();
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL yellow2_early: fault=%b want 0", fault);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd5) begin
      errors++;
      $display("FAIL yellow2_latch: fault=%b code=%0d want 1/5", fault, fault_code);
    end
    do_reset();
    apply(2'b10, 2'b00, 2'b00);
    ticks(3);
    apply(2'b01, 2'b00, 2'b00);
    ticks(3);
    apply(2'b00, 2'b00, 2'b00);
    ticks(3);
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0) begin
      errors++;
      $display("FAIL yellow3_ok: fault=%b code=%0d want 0/0", fault, fault_code);
    end
  endtask

  task automatic test_stuck_green();
    do_reset();
    apply(2'b10, 2'b00, 2'b00);
    ticks(200);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL green_early: fault=%b want 0", fault);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd6) begin
      errors++;
      $display("FAIL green_latch: fault=%b code=%0d want 1/6", fault, fault_code);
    end
  endtask

  task automatic test_priority();
    do_reset();
    apply(2'b10, 2'b00, 2'b00);
    ticks(199);
    apply(2'b11, 2'b10, 2'b00);
    ticks(2);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL prio_early: fault=%b want 0", fault);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd1) begin
      errors++;
      $display("FAIL prio_latch: fault=%b code=%0d want 1/1", fault, fault_code);
    end
    ticks(5);
    checks++;
    if (fault_code !== 3'd1) begin
      errors++;
      $display("FAIL prio_hold: code=%0d want 1", fault_code);
    end
  endtask

  task automatic test_flash_reset();
    logic [1:0] exp_lt;
    do_reset();
    apply(2'b10, 2'b10, 2'b00);
    ticks(3);
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL flash_fault: fault=%b want 1", fault);
    end
    for (int n = 0; n <= 160; n++) begin
      if (n == 0 || n == 49 || n == 50 || n == 99 || n == 100 || n == 150) begin
`ifdef MONITOR_FLASH_EN
        exp_lt = ((n / HALF) % 2 == 1) ? 2'b11 : 2'b00;
`else
        exp_lt = 2'b00;
`endif
        checks++;
        if (safe_light_ns !== exp_lt || safe_light_ew !== exp_lt) begin
          errors++;
          $display("FAIL flash_n%0d: ns=%b ew=%b want %b", n, safe_light_ns, safe_light_ew, exp_lt);
        end
      end
      if (n != 160) tick();
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({safe_light_ns, safe_light_ew, safe_ped, fault, fault_code} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: got %b want all zero", {safe_light_ns, safe_light_ew, safe_ped, fault, fault_code});
    end
    apply(2'b10, 2'b00, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    ticks(6);
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || safe_light_ns !== 2'b10) begin
      errors++;
      $display("FAIL post_reset: fault=%b code=%0d ns=%b want 0/0/10", fault, fault_code, safe_light_ns);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_conflict();
    test_clear();
    test_level_codes();
    test_illegal_transition();
    test_short_yellow();
    test_stuck_green();
    test_priority();
    test_flash_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
